pht_update_ctrl: RTL and testbench
==================================

# pht_update_ctrl

Sequences branch-resolution updates into the gshare pattern history table and restores the global history register after a misprediction. It buffers resolved branches from the execute stage, arbitrates the single-port PHT between front-end prediction lookups (always higher priority) and its own read-modify-write of 2-bit counters, and drives the GHR shift register's restore write port. It sits beside the GHR shift register and the PHT inside the predictor top.

## Interface
- GHR_W, 14, GHR and PHT index width.
- Q_DEPTH, 4, update queue entries (power of two, at least 2).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- lookup_req  in  1  front end uses the PHT this cycle; the controller must not drive the PHT.
- upd_valid  in  1  resolved branch offered.
- upd_ready  out  1  queue can accept.
- upd_pc  in  GHR_W  branch address bits [13:0].
- upd_ghr  in  GHR_W  GHR snapshot taken at prediction time.
- upd_taken  in  1  resolved direction.
- upd_mispred  in  1  direction was mispredicted.
- pht_rd_en  out  1  PHT read strobe; data is returned one cycle later.
- pht_addr  out  GHR_W  PHT index for the read or write.
- pht_rd_data  in  2  counter value, valid the cycle after pht_rd_en.
- pht_wr_en  out  1  PHT write strobe.
- pht_wr_data  out  2  new counter value.
- ghr_wr_en  out  1  GHR restore strobe.
- ghr_wr_data  out  GHR_W  restored history.
- busy  out  1  queue is non-empty or the FSM is not in IDLE.

## Operation
- An update is accepted when upd_valid and upd_ready are both high. The queue stores {pc, ghr, taken}.
- upd_ready is !full and is computed from registered state. A pop in the same cycle does not make a full queue ready.
- Mispredict recovery: the cycle after an accepted update with upd_mispred=1, ghr_wr_en=1 and ghr_wr_data={upd_ghr[GHR_W-2:0], upd_taken}. The restore is not queued. Back-to-back mispredicts each produce one pulse, in order.
- Index: idx = head.ghr ^ head.pc.
- FSM states are IDLE, CAPT and WR.
  - IDLE: if the queue is non-empty and lookup_req=0, assert pht_rd_en with pht_addr=idx, then go to CAPT. Otherwise stay in IDLE.
  - CAPT: latch pht_rd_data and compute the new counter. Taken gives min(3,c+1). Not-taken gives max(0,c-1).
    - If lookup_req=0: assert pht_wr_en, pop the queue, go to IDLE.
    - If lookup_req=1: go to WR.
  - WR: hold the latched value. When lookup_req=0, write, pop, and go to IDLE.
- pht_rd_en and pht_wr_en are never both asserted, and neither is asserted while lookup_req=1.
- Reset mid-operation: the queue is emptied, the FSM returns to IDLE, pending writes and the GHR restore are dropped.

## Timing
- Reset values: upd_ready=1, and all other outputs 0 (pht_addr, pht_wr_data, ghr_wr_data included).
- Uncontended update latency is 2 cycles, from the IDLE read to the CAPT write. Peak throughput is one update per 2 cycles.
- Each cycle of lookup_req=1 adds one cycle to the update, with no bound. The queue back-pressures through upd_ready.
- ghr_wr_en is a registered pulse, 1 cycle after acceptance, and is independent of the FSM.
- Counter arithmetic is 2-bit unsigned and saturates; it never wraps.
- Queue pointers are log2(Q_DEPTH)+1 bits and wrap modulo 2*Q_DEPTH.

## Configuration
- BP_UPD_SKIP_EN defined: in CAPT/WR, if the new counter equals the old one (saturated), no pht_wr_en is issued. The entry pops in CAPT regardless of lookup_req.
- BP_UPD_SKIP_EN undefined: every update issues a write, even when the value is unchanged.

## Structure
- The shared predictor header holds:
  - the GHR width;
  - counter encodings (SNT=0, WNT=1, WT=2, ST=3);
  - FSM state encodings;
  - the queue entry width (2*GHR_W+1).
- Sub-module upd_fifo: a synchronous FIFO with push, pop, full and empty, and head data available combinationally.

## Test plan
- Reset with upd_valid=1 → all outputs 0, upd_ready=1, no accept. Release reset → accept next cycle.
- Single update: pc=0x0005, ghr=0x0003, taken=1, pht_rd_data=1 → pht_rd_en with addr 0x0006; next cycle pht_wr_en with data 2; busy falls after the write.
- Contention: lookup_req held high for 3 cycles starting at CAPT → no PHT strobe during those cycles; the write occurs on the first cycle lookup_req=0, with the latched value.
- Saturation: taken with rd_data=3 → wr_data=3 (with the macro: no write, entry popped). Not-taken with rd_data=0 → wr_data=0.
- Mispredict: ghr=0x2AAA, taken=1, mispred=1 → ghr_wr_en the next cycle with 0x1555.
- Full queue: five back-to-back offers while lookup_req=1 → four accepted, upd_ready=0. Drain in FIFO order, four writes.

Source files
------------

// File: rtl/pht_update_ctrl_pkg.sv
// Shared predictor definitions: history width, 2-bit counter and FSM encodings,
// update queue entry width, and the saturating counter step.
package pht_update_ctrl_pkg;

  localparam int unsigned PHT_GHR_W   = 14;
  localparam int unsigned PHT_ENTRY_W = 2 * PHT_GHR_W + 1;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_WR   = 2'd2
  } upd_state_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    r = c;
    if (taken) begin
      if (c != CTR_ST) r = c + 2'd1;
    end else begin
      if (c != CTR_SNT) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pht_update_ctrl_if.sv
// Update, PHT-port and GHR-restore signals of the PHT update controller.
// slave: the controller; master: execute stage / front end / PHT / GHR side.
interface pht_update_ctrl_if
  import pht_update_ctrl_pkg::*;
#(
  parameter int unsigned GHR_W = PHT_GHR_W
);

  logic             lookup_req;
  logic             upd_valid;
  logic             upd_ready;
  logic [GHR_W-1:0] upd_pc;
  logic [GHR_W-1:0] upd_ghr;
  logic             upd_taken;
  logic             upd_mispred;
  logic             pht_rd_en;
  logic [GHR_W-1:0] pht_addr;
  logic [1:0]       pht_rd_data;
  logic             pht_wr_en;
  logic [1:0]       pht_wr_data;
  logic             ghr_wr_en;
  logic [GHR_W-1:0] ghr_wr_data;
  logic             busy;

  modport slave (
    input  lookup_req, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispred, pht_rd_data,
    output upd_ready, pht_rd_en, pht_addr, pht_wr_en, pht_wr_data,
           ghr_wr_en, ghr_wr_data, busy
  );

  modport master (
    output lookup_req, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispred, pht_rd_data,
    input  upd_ready, pht_rd_en, pht_addr, pht_wr_en, pht_wr_data,
           ghr_wr_en, ghr_wr_data, busy
  );

endinterface

// File: rtl/pht_update_ctrl_upd_fifo.sv
// Synchronous update queue; head entry is visible combinationally.
// Pointers carry one extra wrap bit to tell full from empty.
module upd_fifo
  import pht_update_ctrl_pkg::*;
#(
  parameter int unsigned W     = PHT_ENTRY_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok, pop_ok;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pht_update_ctrl.sv
// Queues resolved branches, read-modify-writes gshare PHT counters around front-end
// lookups, and pulses the GHR restore port on mispredicts. Option: BP_UPD_SKIP_EN.
module pht_update_ctrl
  import pht_update_ctrl_pkg::*;
#(
  parameter int unsigned GHR_W   = PHT_GHR_W,
  parameter int unsigned Q_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  pht_update_ctrl_if.slave  bus
);

  localparam int unsigned ENTRY_W = 2 * GHR_W + 1;

  logic               full, empty, push, pop;
  logic [ENTRY_W-1:0] head;
  logic [GHR_W-1:0]   head_pc, head_ghr, idx;
  logic               head_taken;

  upd_state_e         state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [1:0]         new_cnt;
  logic               rd_en, wr_en;
  logic [1:0]         wr_data;
  logic               ghr_wr_en_q, ghr_wr_en_d;
  logic [GHR_W-1:0]   ghr_wr_data_q, ghr_wr_data_d;

  assign push = bus.upd_valid & ~full;

  upd_fifo #(
    .W     (ENTRY_W),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({bus.upd_pc, bus.upd_ghr, bus.upd_taken}),
    .pop       (pop),
    .head_data (head),
    .full      (full),
    .empty     (empty)
  );

  assign {head_pc, head_ghr, head_taken} = head;
  assign idx     = head_ghr ^ head_pc;
  assign new_cnt = ctr_next(bus.pht_rd_data, head_taken);

  // PHT strobes are gated by the same-cycle lookup_req, so they are decoded from
  // the registered state rather than registered themselves.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && !bus.lookup_req) begin
          rd_en   = 1'b1;
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        cnt_d = new_cnt;
`ifdef BP_UPD_SKIP_EN
        if (new_cnt == bus.pht_rd_data) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end else
`endif
        if (!bus.lookup_req) begin
          wr_en   = 1'b1;
          wr_data = new_cnt;
          pop     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (!bus.lookup_req) begin
          wr_en   = 1'b1;
          wr_data = cnt_q;
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ghr_wr_en_d   = push & bus.upd_mispred;
    ghr_wr_data_d = ghr_wr_data_q;
    if (push && bus.upd_mispred) ghr_wr_data_d = {bus.upd_ghr[GHR_W-2:0], bus.upd_taken};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      ghr_wr_en_q   <= 1'b0;
      ghr_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ghr_wr_en_q   <= ghr_wr_en_d;
      ghr_wr_data_q <= ghr_wr_data_d;
    end
  end

  assign bus.upd_ready   = ~full;
  assign bus.pht_rd_en   = rd_en;
  assign bus.pht_wr_en   = wr_en;
  assign bus.pht_addr    = (rd_en || wr_en) ? idx : '0;
  assign bus.pht_wr_data = wr_data;
  assign bus.ghr_wr_en   = ghr_wr_en_q;
  assign bus.ghr_wr_data = ghr_wr_data_q;
  assign bus.busy        = ~empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_pht_update_ctrl.sv
// Scoreboard bench for pht_update_ctrl: expected PHT writes and GHR restores are
// queued at acceptance and compared against what the DUT emits.
module tb_pht_update_ctrl;

  localparam int GW = 14;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pht_update_ctrl_if #(.GHR_W(GW)) bus ();

  pht_update_ctrl #(.GHR_W(GW), .Q_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;

  logic [1:0]    pht_mem [0:(1<<GW)-1];
  logic [GW+1:0] exp_wr_q[$];
  logic [GW+1:0] obs_wr_q[$];
  logic [GW-1:0] exp_ghr_q[$];
  logic [GW-1:0] obs_ghr_q[$];

  // PHT model: registered read; when not reading, the data bus toggles so a stale
  // capture cannot pass by accident.
  always @(posedge clk) begin
    if (bus.pht_rd_en) bus.pht_rd_data <= pht_mem[bus.pht_addr];
    else               bus.pht_rd_data <= bus.pht_rd_data ^ 2'b11;
  end

  always @(negedge clk) begin
    #2;
    if (bus.pht_wr_en) obs_wr_q.push_back({bus.pht_addr, bus.pht_wr_data});
    if (bus.ghr_wr_en) obs_ghr_q.push_back(bus.ghr_wr_data);
    if ((bus.pht_rd_en && bus.pht_wr_en) ||
        (bus.lookup_req && (bus.pht_rd_en || bus.pht_wr_en))) viol++;
  end

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return v[1:0];
  endfunction

  // Called at a falling edge; offers one update for one cycle and records expectations.
  task automatic offer(input logic [GW-1:0] pc, input logic [GW-1:0] ghr,
                       input logic taken, input logic mis, output logic acc);
    logic [GW-1:0] idx;
    logic [1:0]    nw;
    bus.upd_valid   = 1'b1;
    bus.upd_pc      = pc;
    bus.upd_ghr     = ghr;
    bus.upd_taken   = taken;
    bus.upd_mispred = mis;
    #1;
    acc = bus.upd_ready && reset;
    if (acc) begin
      idx = pc ^ ghr;
      nw  = sat_step(pht_mem[idx], taken);
`ifdef BP_UPD_SKIP_EN
      if (nw != pht_mem[idx]) exp_wr_q.push_back({idx, nw});
`else
      exp_wr_q.push_back({idx, nw});
`endif
      if (mis) exp_ghr_q.push_back({ghr[GW-2:0], taken});
    end
    @(negedge clk);
    bus.upd_valid   = 1'b0;
    bus.upd_mispred = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (bus.busy && cyc < 60) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    @(negedge clk);
    #3;
  endtask

  task automatic test_reset();
    logic acc;
    pht_mem[14'h0011] = 2'd2;
    bus.upd_valid = 1'b1; bus.upd_pc = 14'h0010; bus.upd_ghr = 14'h0001;
    bus.upd_taken = 1'b0; bus.upd_mispred = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus.upd_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", bus.upd_ready); else n_pass++;
    n_checks++; if (bus.pht_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %0b want 0", bus.pht_rd_en); else n_pass++;
    n_checks++; if (bus.pht_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %0b want 0", bus.pht_wr_en); else n_pass++;
    n_checks++; if (bus.pht_addr !== 14'h0) $display("FAIL rst_addr: got %h want 0", bus.pht_addr); else n_pass++;
    n_checks++; if (bus.pht_wr_data !== 2'd0) $display("FAIL rst_wr_data: got %0d want 0", bus.pht_wr_data); else n_pass++;
    n_checks++; if (bus.ghr_wr_en !== 1'b0) $display("FAIL rst_ghr_en: got %0b want 0", bus.ghr_wr_en); else n_pass++;
    n_checks++; if (bus.ghr_wr_data !== 14'h0) $display("FAIL rst_ghr_data: got %h want 0", bus.ghr_wr_data); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", bus.busy); else n_pass++;
    reset = 1'b1;
    offer(14'h0010, 14'h0001, 1'b0, 1'b0, acc);
    #1;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL rst_release_accept: busy=%0b want 1", bus.busy); else n_pass++;
    wait_idle();
    n_checks++; if (obs_wr_q.size() != exp_wr_q.size()) $display("FAIL rst_wr_count: got %0d want %0d", obs_wr_q.size(), exp_wr_q.size()); else n_pass++;
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      logic [GW+1:0] e, o;
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL rst_wr: got %h want %h", o, e); else n_pass++;
    end
    exp_wr_q.delete(); obs_wr_q.delete();
  endtask

  task automatic test_single();
    logic acc;
    pht_mem[14'h0006] = 2'd1;
    @(negedge clk);
    offer(14'h0005, 14'h0003, 1'b1, 1'b0, acc);
    #1;
    n_checks++; if (bus.pht_rd_en !== 1'b1) $display("FAIL single_rd_en: got %0b want 1", bus.pht_rd_en); else n_pass++;
    n_checks++; if (bus.pht_addr !== 14'h0006) $display("FAIL single_rd_addr: got %h want 0006", bus.pht_addr); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.pht_wr_en !== 1'b1) $display("FAIL single_wr_en: got %0b want 1", bus.pht_wr_en); else n_pass++;
    n_checks++; if (bus.pht_wr_data !== 2'd2) $display("FAIL single_wr_data: got %0d want 2", bus.pht_wr_data); else n_pass++;
    n_checks++; if (bus.pht_rd_en !== 1'b0) $display("FAIL single_rd_during_wr: got %0b want 0", bus.pht_rd_en); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy_after: got %0b want 0", bus.busy); else n_pass++;
    wait_idle();
    n_checks++; if (obs_wr_q.size() != exp_wr_q.size()) $display("FAIL single_wr_count: got %0d want %0d", obs_wr_q.size(), exp_wr_q.size()); else n_pass++;
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      logic [GW+1:0] e, o;
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL single_wr: got %h want %h", o, e); else n_pass++;
    end
    exp_wr_q.delete(); obs_wr_q.delete();
  endtask

  task automatic test_contention();
    logic acc;
    pht_mem[14'h01F0] = 2'd0;
    @(negedge clk);
    offer(14'h0100, 14'h00F0, 1'b1, 1'b0, acc);
    #1;
    n_checks++; if (bus.pht_rd_en !== 1'b1) $display("FAIL cont_rd_en: got %0b want 1", bus.pht_rd_en); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.lookup_req = 1'b1;
      #1;
      n_checks++;
      if (bus.pht_rd_en !== 1'b0 || bus.pht_wr_en !== 1'b0)
        $display("FAIL cont_stall%0d: rd=%0b wr=%0b want 0 0", c, bus.pht_rd_en, bus.pht_wr_en);
      else n_pass++;
    end
    @(negedge clk);
    bus.lookup_req = 1'b0;
    #1;
    n_checks++; if (bus.pht_wr_en !== 1'b1) $display("FAIL cont_wr_en: got %0b want 1", bus.pht_wr_en); else n_pass++;
    n_checks++; if (bus.pht_wr_data !== 2'd1) $display("FAIL cont_wr_data: got %0d want 1", bus.pht_wr_data); else n_pass++;
    n_checks++; if (bus.pht_addr !== 14'h01F0) $display("FAIL cont_wr_addr: got %h want 01f0", bus.pht_addr); else n_pass++;
    wait_idle();
    n_checks++; if (obs_wr_q.size() != exp_wr_q.size()) $display("FAIL cont_wr_count: got %0d want %0d", obs_wr_q.size(), exp_wr_q.size()); else n_pass++;
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      logic [GW+1:0] e, o;
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL cont_wr: got %h want %h", o, e); else n_pass++;
    end
    exp_wr_q.delete(); obs_wr_q.delete();
  endtask

  task automatic test_saturation();
    logic acc;
    pht_mem[14'h00A0] = 2'd3;
    pht_mem[14'h00B1] = 2'd0;
    @(negedge clk);
    offer(14'h00A0, 14'h0000, 1'b1, 1'b0, acc);
    offer(14'h00B0, 14'h0001, 1'b0, 1'b0, acc);
    wait_idle();
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL sat_drain: busy=%0b want 0", bus.busy); else n_pass++;
    n_checks++; if (obs_wr_q.size() != exp_wr_q.size()) $display("FAIL sat_wr_count: got %0d want %0d", obs_wr_q.size(), exp_wr_q.size()); else n_pass++;
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      logic [GW+1:0] e, o;
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL sat_wr: got %h want %h", o, e); else n_pass++;
    end
    exp_wr_q.delete(); obs_wr_q.delete();
  endtask

  task automatic test_mispred();
    logic acc;
    pht_mem[14'h2AAA] = 2'd1;
    pht_mem[14'h0301] = 2'd2;
    pht_mem[14'h3CFE] = 2'd1;
    @(negedge clk);
    offer(14'h0000, 14'h2AAA, 1'b1, 1'b1, acc);
    #1;
    n_checks++; if (bus.ghr_wr_en !== 1'b1) $display("FAIL mis_ghr_en: got %0b want 1", bus.ghr_wr_en); else n_pass++;
    n_checks++; if (bus.ghr_wr_data !== 14'h1555) $display("FAIL mis_ghr_data: got %h want 1555", bus.ghr_wr_data); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.ghr_wr_en !== 1'b0) $display("FAIL mis_ghr_pulse: got %0b want 0", bus.ghr_wr_en); else n_pass++;
    @(negedge clk);
    offer(14'h0300, 14'h0001, 1'b0, 1'b1, acc);
    offer(14'h0301, 14'h3FFF, 1'b1, 1'b1, acc);
    wait_idle();
    n_checks++; if (obs_ghr_q.size() != exp_ghr_q.size()) $display("FAIL mis_ghr_count: got %0d want %0d", obs_ghr_q.size(), exp_ghr_q.size()); else n_pass++;
    while (exp_ghr_q.size() > 0 && obs_ghr_q.size() > 0) begin
      logic [GW-1:0] e, o;
      e = exp_ghr_q.pop_front(); o = obs_ghr_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL mis_ghr: got %h want %h", o, e); else n_pass++;
    end
    n_checks++; if (obs_wr_q.size() != exp_wr_q.size()) $display("FAIL mis_wr_count: got %0d want %0d", obs_wr_q.size(), exp_wr_q.size()); else n_pass++;
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      logic [GW+1:0] e, o;
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL mis_wr: got %h want %h", o, e); else n_pass++;
    end
    exp_wr_q.delete(); obs_wr_q.delete(); exp_ghr_q.delete(); obs_ghr_q.delete();
  endtask

  task automatic test_full_queue();
    logic acc;
    int   n_acc;
    logic [GW-1:0] pc, ghr;
    n_acc = 0;
    @(negedge clk);
    bus.lookup_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ghr = GW'(i);
      pc  = 14'h0400 + GW'(i << 4);
      pht_mem[pc ^ ghr] = 2'(i);
      offer(pc, ghr, i[0], 1'b0, acc);
      if (acc) n_acc++;
    end
    #1;
    n_checks++; if (n_acc != 4) $display("FAIL full_accepts: got %0d want 4", n_acc); else n_pass++;
    n_checks++; if (bus.upd_ready !== 1'b0) $display("FAIL full_ready: got %0b want 0", bus.upd_ready); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL full_busy: got %0b want 1", bus.busy); else n_pass++;
    @(negedge clk);
    bus.lookup_req = 1'b0;
    #1;
    wait_idle();
    n_checks++; if (obs_wr_q.size() != exp_wr_q.size()) $display("FAIL full_wr_count: got %0d want %0d", obs_wr_q.size(), exp_wr_q.size()); else n_pass++;
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      logic [GW+1:0] e, o;
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL full_wr: got %h want %h", o, e); else n_pass++;
    end
    exp_wr_q.delete(); obs_wr_q.delete();
  endtask

  task automatic test_reset_mid();
    logic acc;
    pht_mem[14'h0555] = 2'd1;
    @(negedge clk);
    offer(14'h0555, 14'h0000, 1'b1, 1'b0, acc);
    bus.lookup_req = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %0b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.upd_ready !== 1'b1) $display("FAIL midrst_ready: got %0b want 1", bus.upd_ready); else n_pass++;
    exp_wr_q.delete();
    bus.lookup_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_pc = 14'h0777; bus.upd_ghr = 14'h0100;
    bus.upd_taken = 1'b1; bus.upd_mispred = 1'b1;
    pht_mem[14'h0677] = 2'd1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.ghr_wr_en !== 1'b0) $display("FAIL midrst_ghr_drop: got %0b want 0", bus.ghr_wr_en); else n_pass++;
    bus.upd_valid = 1'b0; bus.upd_mispred = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    n_checks++; if (obs_wr_q.size() != 0) $display("FAIL midrst_no_write: got %0d writes want 0", obs_wr_q.size()); else n_pass++;
    n_checks++; if (obs_ghr_q.size() != 0) $display("FAIL midrst_no_ghr: got %0d restores want 0", obs_ghr_q.size()); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_idle: busy=%0b want 0", bus.busy); else n_pass++;
    obs_wr_q.delete(); obs_ghr_q.delete();
  endtask

  task automatic test_protocol();
    n_checks++; if (viol != 0) $display("FAIL protocol: got %0d strobe conflicts want 0", viol); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << GW); i++) pht_mem[i] = 2'd0;
    bus.lookup_req  = 1'b0;
    bus.upd_valid   = 1'b0;
    bus.upd_pc      = '0;
    bus.upd_ghr     = '0;
    bus.upd_taken   = 1'b0;
    bus.upd_mispred = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_saturation();
    test_mispred();
    test_full_queue();
    test_reset_mid();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
